// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared constants, state type and segment codes for digit_scanner
//
// Purpose: digit geometry of the counter bus, the scanner state enum and the
// seven-segment patterns ({g,f,e,d,c,b,a}, active high).
// Ports: none (package).
package scan_pkg;

  localparam int NUM_DIGITS = 9;
  localparam int DIGIT_W    = 5;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHOW,
    GAP
  } scan_state_e;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // digit_idx value presented whenever no digit is being shown
  localparam logic [3:0] IDX_NONE = 4'hF;

endpackage

// File: rtl/digit_scanner_if.sv
// rtl/digit_scanner_if.sv - counter-side inputs and display-side outputs of digit_scanner
//
// Purpose: bundles the scanner's data/control inputs and display outputs.
// Signals:
//   en          - hold everything when low
//   lzb         - leading-zero blanking request, captured once per frame
//   digits      - nine 5-bit digits, ones at [4:0]
//   seg         - segment pattern {g,f,e,d,c,b,a}
//   dp          - decimal point, lit while ones is shown
//   digit_idx   - shown digit index 8..0, F otherwise
//   frame_start - high for the single frame-load cycle
// Modports: master drives en/lzb/digits, slave (the scanner) drives the rest.
interface digit_scanner_if;
  import scan_pkg::*;

  logic                          en;
  logic                          lzb;
  logic [NUM_DIGITS*DIGIT_W-1:0] digits;
  logic [6:0]                    seg;
  logic                          dp;
  logic [3:0]                    digit_idx;
  logic                          frame_start;

  modport master (
    output en, lzb, digits,
    input  seg, dp, digit_idx, frame_start
  );

  modport slave (
    input  en, lzb, digits,
    output seg, dp, digit_idx, frame_start
  );

endinterface

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational nibble to seven-segment pattern
//
// Purpose: maps 0..9 to their digit patterns and 10..15 to a minus sign.
// Ports:
//   nib - 4-bit digit value
//   seg - segment pattern {g,f,e,d,c,b,a}, active high
module seg7_decode
  import scan_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/digit_scanner.sv
// rtl/digit_scanner.sv - frame-snapshotting multiplexed 7-segment digit scanner
//
// Purpose: once per frame latches the nine counter digits, then shows them
// most-significant first, DWELL cycles each, followed by GAP blank cycles.
// Parameters: DWELL (>=1) cycles per digit, GAP (>=0) blank cycles per frame.
// Ports:
//   CLK - clock
//   RST - synchronous active-high reset
//   bus - digit_scanner_if slave (en, lzb, digits in; seg, dp, digit_idx, frame_start out)
module digit_scanner #(
  parameter int DWELL = 1000,
  parameter int GAP   = 2000
) (
  input  logic            CLK,
  input  logic            RST,
  digit_scanner_if.slave  bus
);
  import scan_pkg::*;

  localparam int MAX_CNT = (DWELL > GAP) ? ((DWELL > 2) ? DWELL : 2)
                                         : ((GAP > 2) ? GAP : 2);
  localparam int CW      = $clog2(MAX_CNT);
  localparam int SNAP_W  = NUM_DIGITS * 4;

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [3:0]    TOP_IDX    = 4'(NUM_DIGITS - 1);

  scan_state_e       state, state_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [3:0]        idx, idx_d;
  logic [SNAP_W-1:0] snap, snap_d;   // only the value nibbles are kept
  logic              lzb_q, lzb_d;

  logic [NUM_DIGITS-1:0] unused_digit_msb;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= scan_pkg::IDLE;
      cnt   <= '0;
      idx   <= '0;
      snap  <= '0;
      lzb_q <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
      snap  <= snap_d;
      lzb_q <= lzb_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    snap_d  = snap;
    lzb_d   = lzb_q;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      unused_digit_msb[k] = bus.digits[k*DIGIT_W + 4];
    end
    if (bus.en) begin
      case (state)
        scan_pkg::IDLE: state_d = scan_pkg::LOAD;
        scan_pkg::LOAD: begin
          state_d = scan_pkg::SHOW;
          idx_d   = TOP_IDX;
          cnt_d   = DWELL_LAST;
          lzb_d   = bus.lzb;
          for (int k = 0; k < NUM_DIGITS; k++) begin
            snap_d[k*4 +: 4] = bus.digits[k*DIGIT_W +: 4];
          end
        end
        scan_pkg::SHOW: begin
          if (cnt == '0) begin
            if (idx == '0) begin
              if (GAP == 0) begin
                state_d = scan_pkg::LOAD;
              end else begin
                state_d = scan_pkg::GAP;
                cnt_d   = GAP_LAST;
              end
            end else begin
              idx_d = idx - 4'd1;
              cnt_d = DWELL_LAST;
            end
          end else begin
            cnt_d = cnt - 1'b1;
          end
        end
        scan_pkg::GAP: begin
          if (cnt == '0) begin
            state_d = scan_pkg::LOAD;
          end else begin
            cnt_d = cnt - 1'b1;
          end
        end
        default: state_d = scan_pkg::IDLE;
      endcase
    end
  end

  // Select the shown nibble and detect whether any digit at or above the
  // shown position is non-zero (a zero run from the top means "leading").
  logic [3:0] cur_nib;
  logic       upper_nz;
  logic       blank;
  logic       show;
  logic [6:0] dec_seg;

  always_comb begin
    cur_nib  = '0;
    upper_nz = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (4'(k) == idx) begin
        cur_nib = snap[k*4 +: 4];
      end
      if ((4'(k) >= idx) && (snap[k*4 +: 4] != 4'd0)) begin
        upper_nz = 1'b1;
      end
    end
  end

  // Ones is never blanked so a zero value still shows a single "0".
  assign blank = lzb_q && (idx != 4'd0) && !upper_nz;
  assign show  = (state == scan_pkg::SHOW);

  seg7_decode u_decode (
    .nib (cur_nib),
    .seg (dec_seg)
  );

  assign bus.seg         = (show && !blank) ? dec_seg : SEG_BLANK;
  assign bus.dp          = show && (idx == 4'd0);
  assign bus.digit_idx   = show ? idx : IDX_NONE;
  assign bus.frame_start = (state == scan_pkg::LOAD);

endmodule
